lut_arbiter: RTL and testbench

- Shares one LUT processing unit (single-bit table lookup, address = {sel, args}) between NUM_REQ requesters.
- Round-robin arbitration. The granted request's 1-bit arguments are serialised into the LUT as MAX_NUM_ARGS write cycles, then one output-enable cycle; the result bit returns to the granted requester.
- Sits between requester PUs/glue logic and the LUT unit's signal_wr/signal_oe/signal_sel/data_in/data_out pins.

---
 rtl/lut_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_lut_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_arbiter.sv
// Round-robin arbiter sharing one single-bit LUT unit between NUM_REQ requesters.
// Define LUT_ARB_STATS_EN to add the stat_ops / stat_conflicts counters.
module lut_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned SEL_WIDTH    = 4,
    parameter int unsigned MAX_NUM_ARGS = 2,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*SEL_WIDTH-1:0]      req_sel,
    input  logic [NUM_REQ*MAX_NUM_ARGS-1:0]   req_args,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic                              resp_data,
    output logic                              busy,
    output logic                              lut_signal_wr,
    output logic                              lut_signal_oe,
    output logic [SEL_WIDTH-1:0]              lut_signal_sel,
    output logic [DATA_WIDTH-1:0]             lut_data_in,
    input  logic [DATA_WIDTH-1:0]             lut_data_out
`ifdef LUT_ARB_STATS_EN
    ,
    output logic [15:0]                       stat_ops,
    output logic [15:0]                       stat_conflicts
`endif
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned IW = (MAX_NUM_ARGS > 1) ? $clog2(MAX_NUM_ARGS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_NUM_ARGS - 1);
    localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           last_q, last_d;
    logic [PW-1:0]           gnt_q, gnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [MAX_NUM_ARGS-1:0] args_q, args_d;
    logic                    wr_q, wr_d;
    logic                    oe_q, oe_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic                    din_q, din_d;
    logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic                    resp_data_q, resp_data_d;

    logic                    found_c;
    logic [PW-1:0]           gnt_c;
    logic [SEL_WIDTH-1:0]    gnt_sel_c;
    logic [MAX_NUM_ARGS-1:0] gnt_args_c;
    logic                    multi_c;
    int unsigned             cand;

    // Only bit 0 of the LUT result carries information.
    logic unused_data_hi;
    assign unused_data_hi = ^lut_data_out[DATA_WIDTH-1:1];

    // Round-robin search starting one past the last grant, modulo NUM_REQ.
    always_comb begin
        found_c = 1'b0;
        gnt_c   = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_q) + k) % NUM_REQ;
            if (!found_c && req[PW'(cand)]) begin
                found_c = 1'b1;
                gnt_c   = PW'(cand);
            end
        end
    end

    always_comb begin
        gnt_sel_c  = '0;
        gnt_args_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c == PW'(i)) begin
                gnt_sel_c  = req_sel[i*SEL_WIDTH +: SEL_WIDTH];
                gnt_args_c = req_args[i*MAX_NUM_ARGS +: MAX_NUM_ARGS];
            end
        end
    end

    assign multi_c = |(req & (req - NUM_REQ'(1)));

    // Next-state and next-output computation; outputs are registered from these.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        idx_d        = idx_q;
        args_d       = args_q;
        wr_d         = 1'b0;
        oe_d         = 1'b0;
        sel_d        = '0;
        din_d        = 1'b0;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        case (state_q)
            S_FLUSH: begin
                // The oe pulse is driven in the first cycle after reset release.
                if (oe_q) begin
                    state_d = S_IDLE;
                end else begin
                    oe_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (found_c) begin
                    state_d = S_WRITE;
                    last_d  = gnt_c;
                    gnt_d   = gnt_c;
                    idx_d   = '0;
                    args_d  = gnt_args_c;
                    wr_d    = 1'b1;
                    sel_d   = gnt_sel_c;
                    din_d   = gnt_args_c[0];
                end
            end
            S_WRITE: begin
                sel_d = sel_q;
                if (idx_q == LAST_IDX) begin
                    state_d = S_READ;
                    oe_d    = 1'b1;
                end else begin
                    idx_d  = idx_q + IW'(1);
                    args_d = args_q >> 1;
                    wr_d   = 1'b1;
                    din_d  = args_d[0];
                end
            end
            S_READ: begin
                state_d      = S_RESP;
                resp_valid_d = NUM_REQ'(1) << gnt_q;
                resp_data_d  = lut_data_out[0];
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_FLUSH;
            last_q       <= LAST_REQ;
            gnt_q        <= '0;
            idx_q        <= '0;
            args_q       <= '0;
            wr_q         <= 1'b0;
            oe_q         <= 1'b0;
            sel_q        <= '0;
            din_q        <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            idx_q        <= idx_d;
            args_q       <= args_d;
            wr_q         <= wr_d;
            oe_q         <= oe_d;
            sel_q        <= sel_d;
            din_q        <= din_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Accept pulse must track the live request level, so it is decoded from IDLE.
    assign req_ready      = (state_q == S_IDLE && found_c) ? (NUM_REQ'(1) << gnt_c) : '0;
    assign busy           = (state_q != S_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign lut_signal_wr  = wr_q;
    assign lut_signal_oe  = oe_q;
    assign lut_signal_sel = sel_q;
    assign lut_data_in    = {{(DATA_WIDTH-1){1'b0}}, din_q};

`ifdef LUT_ARB_STATS_EN
    logic [15:0] stat_ops_q;
    logic [15:0] stat_conflicts_q;

    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_ops_q       <= '0;
            stat_conflicts_q <= '0;
        end else begin
            if (state_q == S_RESP && stat_ops_q != 16'hFFFF) begin
                stat_ops_q <= stat_ops_q + 16'd1;
            end
            if (state_q == S_IDLE && found_c && multi_c && stat_conflicts_q != 16'hFFFF) begin
                stat_conflicts_q <= stat_conflicts_q + 16'd1;
            end
        end
    end

    assign stat_ops       = stat_ops_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed bench for lut_arbiter with a behavioural LUT and a response scoreboard.
module tb_lut_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned K  = 2;
    localparam int unsigned DW = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NR-1:0]      req = '0;
    logic [NR*SW-1:0]   req_sel = '0;
    logic [NR*K-1:0]    req_args = '0;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      resp_valid;
    logic               resp_data;
    logic               busy;
    logic               lut_signal_wr;
    logic               lut_signal_oe;
    logic [SW-1:0]      lut_signal_sel;
    logic [DW-1:0]      lut_data_in;
    logic [DW-1:0]      lut_data_out;

    logic [2:0]         req3 = '0;
    logic [2:0]         req_ready3;
    logic [2:0]         resp_valid3;
    logic               resp_data3;
    logic               busy3;
    logic               wr3;
    logic               oe3;
    logic [SW-1:0]      sel3;
    logic [DW-1:0]      din3;
`ifdef LUT_ARB_STATS_EN
    logic [15:0]        stat_ops;
    logic [15:0]        stat_conflicts;
    logic [15:0]        stat_ops3;
    logic [15:0]        stat_conflicts3;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int   g;
        logic d;
        int   t;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   grant_log3[$];

    // Test tables: sel 1 = AND, sel 2 = a0 & ~a1, sel 3 = XOR, others 0.
    function automatic logic tbl(input logic [SW-1:0] s, input logic [K-1:0] a);
        case (s)
            4'd1:    return a[0] & a[1];
            4'd2:    return a[0] & ~a[1];
            4'd3:    return a[0] ^ a[1];
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural LUT: args filled bit 0 first, index cleared by oe.
    logic [K-1:0] lut_args = '0;
    int           lut_idx  = 0;
    always @(posedge clk) begin
        if (lut_signal_wr) begin
            lut_args[lut_idx] <= lut_data_in[0];
            lut_idx <= (lut_idx + 1) % K;
        end else if (lut_signal_oe) begin
            lut_idx <= 0;
        end
    end
    assign lut_data_out = lut_signal_oe ? DW'(tbl(lut_signal_sel, lut_args)) : '0;

    lut_arbiter #(.NUM_REQ(NR), .SEL_WIDTH(SW), .MAX_NUM_ARGS(K), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_sel        (req_sel),
        .req_args       (req_args),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .busy           (busy),
        .lut_signal_wr  (lut_signal_wr),
        .lut_signal_oe  (lut_signal_oe),
        .lut_signal_sel (lut_signal_sel),
        .lut_data_in    (lut_data_in),
        .lut_data_out   (lut_data_out)
`ifdef LUT_ARB_STATS_EN
        ,
        .stat_ops       (stat_ops),
        .stat_conflicts (stat_conflicts)
`endif
    );

    lut_arbiter #(.NUM_REQ(3), .SEL_WIDTH(SW), .MAX_NUM_ARGS(K), .DATA_WIDTH(DW)) dut3 (
        .clk            (clk),
        .rst            (rst),
        .req            (req3),
        .req_sel        ('0),
        .req_args       ('0),
        .req_ready      (req_ready3),
        .resp_valid     (resp_valid3),
        .resp_data      (resp_data3),
        .busy           (busy3),
        .lut_signal_wr  (wr3),
        .lut_signal_oe  (oe3),
        .lut_signal_sel (sel3),
        .lut_data_in    (din3),
        .lut_data_out   ('0)
`ifdef LUT_ARB_STATS_EN
        ,
        .stat_ops       (stat_ops3),
        .stat_conflicts (stat_conflicts3)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle invariants, grant logging and scoreboard push/pop.
    always @(negedge clk) begin : mon
        int   g;
        exp_t e;
        if (rst) begin
            check("wr_oe_exclusive", 64'(lut_signal_wr & lut_signal_oe), 0);
            if (!lut_signal_wr) check("din_zero_without_wr", lut_data_in, 0);
            if (!lut_signal_wr && !lut_signal_oe) check("sel_zero_when_quiet", lut_signal_sel, 0);
            if (req_ready != '0) begin
                check("ready_onehot", 64'($onehot(req_ready)), 1);
                g = 0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
                e.g = g;
                e.d = tbl(req_sel[g*SW +: SW], req_args[g*K +: K]);
                e.t = cyc;
                sb.push_back(e);
                grant_log.push_back(g);
                grant_cyc.push_back(cyc);
            end
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", resp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_requester", resp_valid, 64'(NR'(1) << e.g));
                    check("resp_data", 64'(resp_data), 64'(e.d));
                    check("resp_latency", 64'(cyc - e.t), 64'(K + 2));
                end
            end
            if (req_ready3 != '0) begin
                for (int i = 0; i < 3; i++) if (req_ready3[i]) grant_log3.push_back(i);
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(busy), 0);
    endtask

    // Assert reset, check reset outputs, release and check the flush pulse.
    task automatic do_reset(input int cycles, input logic [NR-1:0] hold, input logic [2:0] hold3);
        bit seen_oe = 0;
        bit early_wr = 0;
        @(negedge clk);
        rst  = 1'b0;
        req  = hold;
        req3 = hold3;
        repeat (cycles) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", 64'(resp_data), 0);
        check("rst_wr", 64'(lut_signal_wr), 0);
        check("rst_oe", 64'(lut_signal_oe), 0);
        check("rst_sel", lut_signal_sel, 0);
        check("rst_data_in", lut_data_in, 0);
        check("rst_busy", 64'(busy), 1);
        sb.delete();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (lut_signal_wr && !seen_oe) early_wr = 1;
            if (lut_signal_oe) begin
                seen_oe = 1;
                check("flush_sel", lut_signal_sel, 0);
            end
            if (!busy) break;
        end
        check("flush_oe_seen", 64'(seen_oe), 1);
        check("flush_before_wr", 64'(early_wr), 0);
        check("idle_after_flush", 64'(busy), 0);
    endtask

    // One solo operation from an IDLE negedge; optional short-lived request from another port.
    task automatic run_op(input int g, input logic [SW-1:0] s, input logic [K-1:0] a, input int glitch);
        logic e;
        e = tbl(s, a);
        check("pre_idle", 64'(busy), 0);
        req_sel[g*SW +: SW] = s;
        req_args[g*K +: K]  = a;
        req[g] = 1'b1;
        #1;
        check("accept_ready", req_ready, 64'(NR'(1) << g));
        for (int k = 0; k < int'(K); k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                req[g] = 1'b0;
                req_sel[g*SW +: SW] = ~s;
                req_args[g*K +: K]  = ~a;
                if (glitch >= 0) req[glitch] = 1'b1;
            end else if (k == 1 && glitch >= 0) begin
                req[glitch] = 1'b0;
            end
            @(negedge clk);
            check("write_wr", 64'(lut_signal_wr), 1);
            check("write_data", lut_data_in, 64'(a[k]));
            check("write_sel", lut_signal_sel, 64'(s));
            check("write_no_ready", req_ready, 0);
        end
        @(negedge clk);
        check("read_oe", 64'(lut_signal_oe), 1);
        check("read_sel", lut_signal_sel, 64'(s));
        @(negedge clk);
        check("resp_strobe", resp_valid, 64'(NR'(1) << g));
        check("resp_bit", 64'(resp_data), 64'(e));
        @(negedge clk);
        check("post_idle", 64'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp4[5] = '{0, 1, 2, 3, 0};
        int exp3[4] = '{0, 2, 0, 2};

        do_reset(3, '0, '0);

        // AND table, both args set, then one arg set with a short-lived foreign request.
        run_op(2, 4'd1, 2'b11, -1);
        n = grant_log.size();
        run_op(2, 4'd1, 2'b01, 0);
        @(negedge clk);
        check("dropped_req_no_grant", 64'(grant_log.size() - n), 1);
        check("dropped_req_no_ready", req_ready, 0);

        // Argument order sensitivity.
        run_op(3, 4'd2, 2'b10, -1);
        run_op(0, 4'd2, 2'b01, -1);
        run_op(1, 4'd3, 2'b11, -1);

        // All requesters held after reset; 3-requester instance with 101 held.
        req_sel  = {4'd3, 4'd2, 4'd2, 4'd1};
        req_args = {2'b01, 2'b01, 2'b10, 2'b11};
        grant_log.delete();
        grant_cyc.delete();
        grant_log3.delete();
        do_reset(2, 4'b1111, 3'b101);
        n = 0;
        while (grant_log.size() < 5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req  = '0;
        req3 = '0;
        check("rr_grants_seen", 64'(grant_log.size() >= 5), 1);
        check("rr3_grants_seen", 64'(grant_log3.size() >= 4), 1);
        for (int i = 0; i < 5; i++) begin
            if (grant_log.size() > i) check("rr_order", 64'(grant_log[i]), 64'(exp4[i]));
            if (i > 0 && grant_cyc.size() > i) check("rr_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 5);
        end
        for (int i = 0; i < 4; i++) begin
            if (grant_log3.size() > i) check("rr3_order", 64'(grant_log3[i]), 64'(exp3[i]));
        end
        @(negedge clk);
        wait_idle("rr_drain_idle");

        // Reset during the first write of a grant to requester 1.
        req_sel[1*SW +: SW] = 4'd1;
        req_args[1*K +: K]  = 2'b11;
        req[1] = 1'b1;
        #1;
        check("midrst_ready", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        check("midrst_in_write", 64'(lut_signal_wr), 1);
        do_reset(2, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_resp", resp_valid, 0);
        end
        run_op(1, 4'd2, 2'b01, -1);
        run_op(1, 4'd1, 2'b11, -1);

`ifdef LUT_ARB_STATS_EN
        do_reset(2, '0, '0);
        check("stat_ops_reset", stat_ops, 0);
        check("stat_conflicts_reset", stat_conflicts, 0);
        req_sel  = {4'd0, 4'd0, 4'd3, 4'd1};
        req_args = {2'b00, 2'b00, 2'b01, 2'b11};
        n = grant_log.size();
        req = 4'b0011;
        for (int i = 0; i < 30 && grant_log.size() < n + 3; i++) @(negedge clk);
        @(posedge clk);
        #1;
        req = '0;
        wait_idle("stats_contended_idle");
        run_op(0, 4'd1, 2'b11, -1);
        run_op(1, 4'd3, 2'b10, -1);
        check("stat_ops", stat_ops, 5);
        check("stat_conflicts", stat_conflicts, 3);
        force dut.stat_ops_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.stat_ops_q;
        @(negedge clk);
        run_op(2, 4'd1, 2'b11, -1);
        check("stat_ops_saturated", stat_ops, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
